// File: rtl/spi_frame_checker_pkg.sv
// Shared definitions for the SPI frame checker: FSM encoding, error codes
// and byte constants.
package spi_frame_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_SEQ     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_CLOSE   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_PAY  = 2'd2;
  localparam logic [1:0] ERR_LEN  = 2'd3;

  localparam logic [7:0] TX_BASE      = 8'h61;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_frame_checker_edge_sync.sv
// Registered edge detector: q follows d, rise/fall pulse one cycle after the
// transition is sampled, aligned with the updated q.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= d;
      rise <= d & ~q;
      fall <= ~d & q;
    end
  end

endmodule

// File: rtl/spi_frame_checker.sv
// Frames SPI slave bytes by SSEL, checks header/sequence/payload pattern,
// counts good/bad frames and supplies the next MISO byte.
//
//  state   | meaning
//  IDLE    | waiting for ssel low
//  HDR     | expecting header byte
//  SEQ     | capturing sequence byte
//  PAYLOAD | each byte must equal previous + 1
//  DRAIN   | error or post-reset partial frame, swallow until ssel high
//  CLOSE   | one cycle: report result, update counters
module spi_frame_checker
  import spi_frame_checker_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned CNT_W    = 16,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ssel,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic [7:0]       tx_byte,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       err_code,
  output logic [5:0]       last_len,
  output logic             busy
);

  localparam logic [5:0] MAX_IDX = 6'(MAX_LEN);

  state_t     state, b_state;
  logic [5:0] idx, b_idx;
  logic [1:0] err, b_err;
  logic [7:0] exp_byte;
  logic       discard, rst_pend;
  logic       ssel_q, ssel_rise, ssel_fall;
  logic       byte_stb, rx_unused_q, rx_unused_fall;
  logic       active, byte_take;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ssel_edge (
    .clk(clk), .rst(rst), .d(ssel), .q(ssel_q), .rise(ssel_rise), .fall(ssel_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_rx_edge (
    .clk(clk), .rst(rst), .d(rx_valid), .q(rx_unused_q), .rise(byte_stb), .fall(rx_unused_fall)
  );

  assign active    = (state == ST_HDR) || (state == ST_SEQ) ||
                     (state == ST_PAYLOAD) || (state == ST_DRAIN);
  assign byte_take = byte_stb && active && (idx != MAX_IDX);
  assign busy      = (state != ST_IDLE);

  // Effect of this cycle's byte, applied before any close on the same cycle.
  always_comb begin
    b_state = state;
    b_err   = err;
    b_idx   = idx;
    if (byte_stb && active) begin
      if (idx == MAX_IDX) begin
        if (state != ST_DRAIN) begin
          b_err   = ERR_LEN;
          b_state = ST_DRAIN;
        end
      end else begin
        b_idx = idx + 6'd1;
        case (state)
          ST_HDR: begin
            if (rx_byte == HDR_BYTE) begin
              b_state = ST_SEQ;
            end else begin
              b_err   = ERR_HDR;
              b_state = ST_DRAIN;
            end
          end
          ST_SEQ: b_state = ST_PAYLOAD;
          ST_PAYLOAD: begin
            if (rx_byte != exp_byte) begin
              b_err   = ERR_PAY;
              b_state = ST_DRAIN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      err       <= ERR_NONE;
      exp_byte  <= '0;
      discard   <= 1'b0;
      rst_pend  <= 1'b1;
      tx_byte   <= TX_BASE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      err_code  <= ERR_NONE;
      last_len  <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          rst_pend <= 1'b0;
          // Right after reset ssel_q is still forced high, so look at ssel itself.
          if (rst_pend ? !ssel : (ssel_fall || !ssel_q)) begin
            state   <= rst_pend ? ST_DRAIN : ST_HDR;
            discard <= rst_pend;
            idx     <= '0;
            err     <= ERR_NONE;
            tx_byte <= TX_BASE;
          end
        end
        ST_CLOSE: begin
          if (err == ERR_NONE) begin
            frame_ok <= 1'b1;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
          end else begin
            frame_err <= 1'b1;
            err_code  <= err;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
          last_len <= idx;
          state    <= ST_IDLE;
        end
        default: begin
          idx <= b_idx;
          err <= b_err;
          if (byte_take) tx_byte <= TX_BASE + {2'b00, b_idx};
          if (byte_take && state == ST_SEQ) begin
            exp_byte <= rx_byte + 8'd1;
          end else if (byte_take && state == ST_PAYLOAD && rx_byte == exp_byte) begin
            exp_byte <= exp_byte + 8'd1;
          end
          if (ssel_rise) begin
            if (discard) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_CLOSE;
              if ((b_state == ST_HDR || b_state == ST_SEQ) && b_err == ERR_NONE) err <= ERR_LEN;
            end
          end else begin
            state <= b_state;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_checker.sv
// Randomized bench for spi_frame_checker with a frame-level reference model
// and a per-cycle output monitor.
module tb_spi_frame_checker;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, ssel, rx_valid;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic          frame_ok, frame_err, busy;
  logic [CW-1:0] frame_cnt, err_cnt;
  logic [1:0]    err_code;
  logic [5:0]    last_len;

  spi_frame_checker #(.MAX_LEN(32), .CNT_W(CW), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .ssel(ssel), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .frame_ok(frame_ok), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_code(err_code),
    .last_len(last_len), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bytes_t[$];
  typedef struct { int err; int len; } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   m_ok, m_err, m_code, m_len;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Frame verdict from position rules: byte 0 header, byte 1 sequence,
  // byte k>=2 must be seq+k-1, at most 32 bytes, at least 2 bytes.
  function automatic void model(input bytes_t b, output int e, output int l);
    int n = b.size();
    e = 0;
    l = (n > 32) ? 32 : n;
    for (int k = 0; k < n; k++) begin
      if (e != 0) break;
      if (k >= 32) e = 3;
      else if (k == 0) begin
        if (b[0] != 8'hA5) e = 1;
      end else if (k >= 2) begin
        if (b[k] != 8'(int'(b[1]) + k - 1)) e = 2;
      end
    end
    if (e == 0 && n < 2) e = 3;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_ok || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", {30'd0, frame_ok, frame_err}, 0);
        end else begin
          cur = exp_q.pop_front();
          if (cur.err == 0) m_ok = (m_ok < CMAX) ? m_ok + 1 : m_ok;
          else begin
            m_err  = (m_err < CMAX) ? m_err + 1 : m_err;
            m_code = cur.err;
          end
          m_len = cur.len;
          chk("frame_ok", frame_ok, (cur.err == 0));
          chk("frame_err", frame_err, (cur.err != 0));
        end
      end
      chk("frame_cnt", frame_cnt, m_ok);
      chk("err_cnt", err_cnt, m_err);
      chk("err_code", err_code, m_code);
      chk("last_len", last_len, m_len);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_close);
    rx_byte  = b;
    rx_valid = 1'b1;
    if (with_close) ssel = 1'b1;
    tick(3);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_close();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick(1);
    if (exp_q.size() != 0) begin
      chk("close_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input bytes_t b, input bit sim_close);
    int   e, l, n;
    exp_t x;
    bit   last;
    n = b.size();
    model(b, e, l);
    x.err = e;
    x.len = l;
    ssel = 1'b0;
    tick(4);
    chk("tx_start", tx_byte, 8'h61);
    chk("busy_in_frame", busy, 1);
    for (int k = 0; k < n; k++) begin
      last = sim_close && (k == n - 1);
      if (last) exp_q.push_back(x);
      send_byte(b[k], last);
      chk("tx_after_byte", tx_byte, 8'(8'h61 + ((k + 1 > 32) ? 32 : k + 1)));
    end
    if (!(sim_close && n > 0)) begin
      exp_q.push_back(x);
      ssel = 1'b1;
    end
    wait_close();
    tick(4);
    chk("busy_idle", busy, 0);
  endtask

  function automatic bytes_t good_frame(input logic [7:0] s, input int n);
    bytes_t b;
    for (int k = 0; k < n; k++) begin
      if (k == 0) b.push_back(8'hA5);
      else b.push_back(8'(int'(s) + k - 1));
    end
    return b;
  endfunction

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bytes_t b;
    int n, kind, pos;
    rst = 1'b1; ssel = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    m_ok = 0; m_err = 0; m_code = 0; m_len = 0;
    tick(3);
    chk("rst_tx", tx_byte, 8'h61);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ecnt", err_cnt, 0);
    chk("rst_code", err_code, 0);
    chk("rst_len", last_len, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(3);
    mon_en = 1'b1;

    run_frame('{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13}, 1'b0);
    chk("t1_fcnt", frame_cnt, 1); chk("t1_len", last_len, 5); chk("t1_code", err_code, 0);
    run_frame('{8'h5A, 8'h00, 8'h33, 8'h44}, 1'b0);
    chk("t2_ecnt", err_cnt, 1); chk("t2_code", err_code, 1); chk("t2_fcnt", frame_cnt, 1);
    run_frame('{8'hA5, 8'hFE, 8'hFF, 8'h00, 8'h02}, 1'b0);
    chk("t3_code", err_code, 2); chk("t3_len", last_len, 5); chk("t3_ecnt", err_cnt, 2);
    run_frame('{8'hA5}, 1'b0);
    chk("t4a_code", err_code, 3); chk("t4a_len", last_len, 1);
    run_frame(good_frame(8'h20, 33), 1'b0);
    chk("t4b_code", err_code, 3); chk("t4b_len", last_len, 32); chk("t4b_tx", tx_byte, 8'h81);
    run_frame('{8'hA5, 8'h40, 8'h41}, 1'b1);
    chk("t5_fcnt", frame_cnt, 2); chk("t5_len", last_len, 3); chk("t5_tx", tx_byte, 8'h64);
    chk("t5_code_hold", err_code, 3);
    run_frame('{}, 1'b0);
    chk("t_empty_len", last_len, 0); chk("t_empty_ecnt", err_cnt, 5);

    // reset mid-frame, released with ssel still low
    ssel = 1'b0;
    tick(4);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h07, 1'b0);
    mon_en = 1'b0;
    rst = 1'b1;
    tick(2);
    m_ok = 0; m_err = 0; m_code = 0; m_len = 0;
    rst = 1'b0;
    tick(1);
    mon_en = 1'b1;
    send_byte(8'h08, 1'b0);
    send_byte(8'h09, 1'b0);
    chk("t6_busy_drain", busy, 1);
    ssel = 1'b1;
    tick(20);
    chk("t6_fcnt0", frame_cnt, 0); chk("t6_ecnt0", err_cnt, 0); chk("t6_busy", busy, 0);
    run_frame('{8'hA5, 8'h01, 8'h02}, 1'b0);
    chk("t6_fcnt1", frame_cnt, 1);

    for (int f = 0; f < 40; f++) begin
      n    = $urandom_range(0, 36);
      kind = $urandom_range(0, 3);
      b    = good_frame(8'($urandom), n);
      if (kind == 1 && n > 0) begin
        pos = $urandom_range(0, n - 1);
        b[pos] = b[pos] ^ 8'($urandom_range(1, 255));
      end else if (kind == 2 && n > 0) begin
        b[0] = 8'($urandom_range(0, 254));
        if (b[0] == 8'hA5) b[0] = 8'h00;
      end else if (kind == 3) begin
        for (int k = 0; k < n; k++) b[k] = 8'($urandom);
      end
      run_frame(b, ($urandom_range(0, 2) == 0));
    end

    for (int f = 0; f < 8; f++) run_frame(good_frame(8'(f * 37), 2 + f), f[0]);
    chk("sat_fcnt", frame_cnt, CMAX);
    for (int f = 0; f < 8; f++) run_frame('{8'h00, 8'h01}, 1'b0);
    chk("sat_ecnt", err_cnt, CMAX);
    chk("sat_code", err_code, 1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
